// File: rtl/dma_pkg.sv
// dma_pkg: shared definitions for the DMA CPU-facing controller.
//   - register offsets within the DMA I/O window
//   - controller state encoding
//   - control register bit positions
//   - dma_hit(): tests whether an address selects a given window offset
package dma_pkg;

    localparam logic [2:0] DMA_SRC_LO = 3'd0;
    localparam logic [2:0] DMA_SRC_HI = 3'd1;
    localparam logic [2:0] DMA_DST_LO = 3'd2;
    localparam logic [2:0] DMA_DST_HI = 3'd3;
    localparam logic [2:0] DMA_LEN    = 3'd4;
    localparam logic [2:0] DMA_CTRL   = 3'd5;

    localparam int unsigned DMA_CTRL_START = 7;
    localparam int unsigned DMA_CTRL_DONE  = 6;

    typedef enum logic [1:0] {
        DMA_IDLE,
        DMA_ARM,
        DMA_RUN,
        DMA_DONE
    } dma_ctrl_state_t;

    function automatic logic dma_hit(input logic [15:0] addr,
                                     input logic [15:0] base,
                                     input logic [2:0]  off);
        logic [15:0] rel;
        rel = addr - base;
        return rel == {13'd0, off};
    endfunction

endpackage

// File: rtl/dma_ctrl_if.sv
// dma_ctrl_if: CPU I/O bus as seen by the DMA controller.
//   cpu_addr/cpu_din/cpu_we/cpu_cs driven by the CPU decode (master),
//   cpu_dout/cpu_rdy driven by the controller (slave).
interface dma_ctrl_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic        cpu_we;
    logic        cpu_cs;
    logic [7:0]  cpu_dout;
    logic        cpu_rdy;

    modport master (
        output cpu_addr, cpu_din, cpu_we, cpu_cs,
        input  cpu_dout, cpu_rdy
    );

    modport slave (
        input  cpu_addr, cpu_din, cpu_we, cpu_cs,
        output cpu_dout, cpu_rdy
    );
endinterface

// File: rtl/dma_regfile.sv
// dma_regfile: the six DMA request registers and their read mux.
//   clk, reset_n : clock, async active-low reset
//   addr, din    : CPU address / write data
//   we           : write enable, already qualified by cs, we and controller state
//   active       : read-back value for control bit 7 (ARM or RUN)
//   done         : read-back value for control bit 6 (done flag)
//   dout         : combinational read data, 0 outside the window
//   src, dst, len, ctrl_lo : register contents (ctrl_lo = control bits 5:0)
module dma_regfile
    import dma_pkg::*;
#(
    parameter logic [15:0] BASE = 16'h2008
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] addr,
    input  logic [7:0]  din,
    input  logic        we,
    input  logic        active,
    input  logic        done,
    output logic [7:0]  dout,
    output logic [15:0] src,
    output logic [15:0] dst,
    output logic [7:0]  len,
    output logic [5:0]  ctrl_lo
);

    // Addresses below BASE wrap to large values, so one compare covers both ends.
    logic [15:0] rel;
    logic        hit;
    logic [2:0]  off;

    assign rel = addr - BASE;
    assign hit = rel < 16'd6;
    assign off = rel[2:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src     <= '0;
            dst     <= '0;
            len     <= '0;
            ctrl_lo <= '0;
        end else if (we && hit) begin
            case (off)
                DMA_SRC_LO: src[7:0]  <= din;
                DMA_SRC_HI: src[15:8] <= din;
                DMA_DST_LO: dst[7:0]  <= din;
                DMA_DST_HI: dst[15:8] <= din;
                DMA_LEN:    len       <= din;
                DMA_CTRL:   ctrl_lo   <= din[5:0];
                default:    ;
            endcase
        end
    end

    always_comb begin
        dout = '0;
        if (hit) begin
            case (off)
                DMA_SRC_LO: dout = src[7:0];
                DMA_SRC_HI: dout = src[15:8];
                DMA_DST_LO: dout = dst[7:0];
                DMA_DST_HI: dout = dst[15:8];
                DMA_LEN:    dout = len;
                DMA_CTRL:   dout = {active, done, ctrl_lo};
                default:    dout = '0;
            endcase
        end
    end

endmodule

// File: rtl/dma_ctrl.sv
// dma_ctrl: CPU-facing responder for the DMA engine.
//   clk, reset_n : system clock, async active-low reset
//   cpu          : CPU I/O bus (dma_ctrl_if.slave); cpu_rdy low stalls the CPU
//   dma_busy     : engine busy
//   src_addr, dst_addr, length, ctrl : engine request registers
//   irq          : completion interrupt
// Optional feature macro: DMA_CTRL_IRQ_EN enables the done flag (control
// bit 6) and irq. Without it irq is 0, bit 6 reads 0 and sequencing is unchanged.
module dma_ctrl
    import dma_pkg::*;
#(
    parameter logic [15:0] BASE        = 16'h2008,
    parameter int unsigned ARM_TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    dma_ctrl_if.slave   cpu,
    input  logic        dma_busy,
    output logic [15:0] src_addr,
    output logic [15:0] dst_addr,
    output logic [7:0]  length,
    output logic [7:0]  ctrl,
    output logic        irq
);

    dma_ctrl_state_t state, state_nxt;
    logic [15:0]     arm_cnt;
    logic            arm_expired;
    logic            idle;
    logic            active;
    logic            ctrl_hit;
    logic            reg_we;
    logic            start_ok;
    logic            done_flag;
    logic [5:0]      ctrl_lo;

    assign idle     = (state == DMA_IDLE);
    assign active   = (state == DMA_ARM) || (state == DMA_RUN);
    assign ctrl_hit = dma_hit(cpu.cpu_addr, BASE, DMA_CTRL);
    assign reg_we   = cpu.cpu_cs && cpu.cpu_we && idle;
    // A start with zero length is dropped: the lower bits are still stored.
    assign start_ok = reg_we && ctrl_hit && cpu.cpu_din[DMA_CTRL_START] && (length != 8'd0);

    // arm_cnt counts completed ARM cycles; the last allowed cycle is ARM_TIMEOUT-1.
    assign arm_expired = (32'(arm_cnt) + 32'd1) >= ARM_TIMEOUT;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= DMA_IDLE;
            arm_cnt <= '0;
        end else begin
            state   <= state_nxt;
            arm_cnt <= (state == DMA_ARM) ? arm_cnt + 16'd1 : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            DMA_IDLE: if (start_ok) state_nxt = DMA_ARM;
            DMA_ARM: begin
                if (dma_busy)         state_nxt = DMA_RUN;
                else if (arm_expired) state_nxt = DMA_DONE;
            end
            DMA_RUN:  if (!dma_busy) state_nxt = DMA_DONE;
            DMA_DONE: state_nxt = DMA_IDLE;
            default:  state_nxt = DMA_IDLE;
        endcase
    end

`ifdef DMA_CTRL_IRQ_EN
    // Set from DONE takes priority over the read-clear of the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_flag <= 1'b0;
        end else if (state == DMA_DONE) begin
            done_flag <= 1'b1;
        end else if (reg_we && ctrl_hit) begin
            done_flag <= start_ok ? 1'b0 : cpu.cpu_din[DMA_CTRL_DONE];
        end else if (cpu.cpu_cs && !cpu.cpu_we && ctrl_hit) begin
            done_flag <= 1'b0;
        end
    end
    assign irq = done_flag;
`else
    assign done_flag = 1'b0;
    assign irq       = 1'b0;
`endif

    // ctrl[7] covers ARM, RUN and DONE so the engine sees it fall only after DONE.
    assign ctrl        = {~idle, done_flag, ctrl_lo};
    assign cpu.cpu_rdy = idle;

    dma_regfile #(
        .BASE(BASE)
    ) u_regfile (
        .clk     (clk),
        .reset_n (reset_n),
        .addr    (cpu.cpu_addr),
        .din     (cpu.cpu_din),
        .we      (reg_we),
        .active  (active),
        .done    (done_flag),
        .dout    (cpu.cpu_dout),
        .src     (src_addr),
        .dst     (dst_addr),
        .len     (length),
        .ctrl_lo (ctrl_lo)
    );

endmodule

// File: tb/tb_dma_ctrl.sv
// tb_dma_ctrl: scoreboard bench for dma_ctrl. Stimulus pushes expected
// observations into a queue; a monitor pops and compares them on the
// falling edge whenever the stimulus raises the probe strobe.
module tb_dma_ctrl;
    import dma_pkg::*;

    localparam logic [15:0] BASE        = 16'h2008;
    localparam int unsigned ARM_TIMEOUT = 4;
`ifdef DMA_CTRL_IRQ_EN
    localparam logic        IRQ_ON  = 1'b1;
`else
    localparam logic        IRQ_ON  = 1'b0;
`endif
    localparam logic [7:0]  DONE_RD = IRQ_ON ? 8'h40 : 8'h00;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b0;
    logic        dma_busy = 1'b0;
    logic [15:0] src_addr, dst_addr;
    logic [7:0]  length, ctrl;
    logic        irq;

    dma_ctrl_if bus();

    dma_ctrl #(
        .BASE        (BASE),
        .ARM_TIMEOUT (ARM_TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cpu      (bus),
        .dma_busy (dma_busy),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .length   (length),
        .ctrl     (ctrl),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    typedef enum {K_DOUT, K_RDY, K_IRQ, K_CTRL, K_SRC, K_DST, K_LEN} kind_t;
    typedef struct {
        kind_t       k;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    logic probe = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [15:0] observe(kind_t k);
        case (k)
            K_DOUT:  return {8'h00, bus.cpu_dout};
            K_RDY:   return {15'd0, bus.cpu_rdy};
            K_IRQ:   return {15'd0, irq};
            K_CTRL:  return {8'h00, ctrl};
            K_SRC:   return src_addr;
            K_DST:   return dst_addr;
            default: return {8'h00, length};
        endcase
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (probe) begin
            while (sb.size() > 0) begin
                exp_t        e;
                logic [15:0] act;
                e   = sb.pop_front();
                act = observe(e.k);
                n_cmp++;
                if (act !== e.exp) begin
                    n_bad++;
                    $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input kind_t k, input logic [15:0] exp, input string name);
        exp_t e;
        e.k = k;
        e.exp = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic sample();
        probe = 1'b1;
        @(negedge clk);
        #1;
        probe = 1'b0;
    endtask

    task automatic wr(input logic [2:0] off, input logic [7:0] data);
        bus.cpu_addr = BASE + {13'd0, off};
        bus.cpu_din  = data;
        bus.cpu_we   = 1'b1;
        bus.cpu_cs   = 1'b1;
        cycle();
        bus.cpu_cs   = 1'b0;
        bus.cpu_we   = 1'b0;
    endtask

    // Read is held through the following edge so a read of offset 5 clears the done flag.
    task automatic rd(input logic [15:0] addr, input logic [7:0] exp, input string name);
        bus.cpu_addr = addr;
        bus.cpu_we   = 1'b0;
        bus.cpu_cs   = 1'b1;
        chk(K_DOUT, {8'h00, exp}, name);
        sample();
        cycle();
        bus.cpu_cs   = 1'b0;
    endtask

    task automatic wait_idle(input int unsigned max_cycles, input string name);
        int unsigned n;
        n = 0;
        while (!bus.cpu_rdy && n < max_cycles) begin
            cycle();
            n++;
        end
        if (!bus.cpu_rdy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: cpu_rdy still %b after %0d cycles, expected 1", name, bus.cpu_rdy, n);
        end
    endtask

    initial begin
        bus.cpu_addr = '0;
        bus.cpu_din  = '0;
        bus.cpu_we   = 1'b0;
        bus.cpu_cs   = 1'b0;
        cycle();
        cycle();

        // Reset state
        chk(K_RDY, 16'd1, "rst_rdy");
        chk(K_IRQ, 16'd0, "rst_irq");
        chk(K_CTRL, 16'h0000, "rst_ctrl");
        chk(K_SRC, 16'h0000, "rst_src");
        rd(BASE + 16'd5, 8'h00, "rst_rd_ctrl");
        reset_n = 1'b1;
        cycle();

        // Normal transfer
        wr(3'd0, 8'h34);
        wr(3'd1, 8'h12);
        wr(3'd2, 8'h00);
        wr(3'd3, 8'h40);
        wr(3'd4, 8'h02);
        chk(K_SRC, 16'h1234, "src");
        chk(K_DST, 16'h4000, "dst");
        chk(K_LEN, 16'h0002, "len");
        rd(BASE, 8'h34, "rd_src_lo");
        rd(BASE + 16'd1, 8'h12, "rd_src_hi");
        rd(BASE + 16'd3, 8'h40, "rd_dst_hi");
        rd(BASE + 16'd4, 8'h02, "rd_len");
        rd(BASE + 16'd6, 8'h00, "rd_above_window");
        rd(BASE - 16'd1, 8'h00, "rd_below_window");

        wr(3'd5, 8'h80);
        dma_busy = 1'b1;
        chk(K_RDY, 16'd0, "arm_rdy");
        chk(K_CTRL, 16'h0080, "arm_ctrl");
        rd(BASE + 16'd5, 8'h80, "rd_ctrl_arm");
        wr(3'd0, 8'hFF);
        rd(BASE + 16'd5, 8'h80, "rd_ctrl_run");
        for (int i = 0; i < 60; i++) begin
            chk(K_RDY, 16'd0, "run_rdy");
            chk(K_CTRL, 16'h0080, "run_ctrl");
            sample();
            cycle();
        end
        dma_busy = 1'b0;
        chk(K_RDY, 16'd0, "busy_fall_rdy");
        chk(K_CTRL, 16'h0080, "busy_fall_ctrl");
        sample();
        cycle();
        // DONE cycle: this read must not win against the done-flag set
        chk(K_RDY, 16'd0, "done_rdy");
        chk(K_CTRL, 16'h0080, "done_ctrl");
        chk(K_IRQ, 16'd0, "done_irq");
        rd(BASE + 16'd5, 8'h00, "rd_ctrl_done");
        chk(K_RDY, 16'd1, "after_rdy");
        chk(K_IRQ, {15'd0, IRQ_ON}, "after_irq");
        chk(K_CTRL, {8'h00, DONE_RD}, "after_ctrl");
        chk(K_SRC, 16'h1234, "src_kept");
        sample();
        rd(BASE + 16'd5, DONE_RD, "rd_ctrl_after");
        chk(K_IRQ, 16'd0, "irq_cleared");
        rd(BASE + 16'd5, 8'h00, "rd_ctrl_cleared");
        rd(BASE, 8'h34, "rd_src_lo_kept");

        // Zero-length start is dropped, lower bits still stored
        wr(3'd4, 8'h00);
        wr(3'd5, 8'h80);
        chk(K_RDY, 16'd1, "len0_rdy");
        chk(K_CTRL, 16'h0000, "len0_ctrl");
        chk(K_IRQ, 16'd0, "len0_irq");
        rd(BASE + 16'd5, 8'h00, "rd_len0_ctrl");
        cycle();
        chk(K_RDY, 16'd1, "len0_rdy_later");
        sample();
        wr(3'd5, 8'h85);
        chk(K_CTRL, 16'h0005, "len0_bits_ctrl");
        chk(K_RDY, 16'd1, "len0_bits_rdy");
        rd(BASE + 16'd5, 8'h05, "rd_len0_bits");
        wr(3'd5, 8'h00);

        // Busy never rises: IDLE again ARM_TIMEOUT+2 cycles after the write
        wr(3'd4, 8'h01);
        wr(3'd5, 8'h80);
        for (int i = 1; i <= ARM_TIMEOUT + 1; i++) begin
            chk(K_RDY, 16'd0, "timeout_rdy_low");
            sample();
            cycle();
        end
        chk(K_RDY, 16'd1, "timeout_rdy_back");
        chk(K_IRQ, {15'd0, IRQ_ON}, "timeout_irq");
        chk(K_CTRL, {8'h00, DONE_RD}, "timeout_ctrl");
        sample();
        // Start while the done flag is set clears it
        wr(3'd5, 8'h80);
        chk(K_IRQ, 16'd0, "restart_irq");
        chk(K_CTRL, 16'h0080, "restart_ctrl");
        rd(BASE + 16'd5, 8'h80, "rd_restart");
        wait_idle(20, "restart_timeout");
        chk(K_IRQ, {15'd0, IRQ_ON}, "restart_done_irq");
        rd(BASE + 16'd5, DONE_RD, "rd_restart_done");
        chk(K_IRQ, 16'd0, "restart_irq_cleared");
        sample();

        // Reset during RUN
        wr(3'd4, 8'h02);
        wr(3'd5, 8'h80);
        dma_busy = 1'b1;
        cycle();
        cycle();
        chk(K_RDY, 16'd0, "pre_reset_rdy");
        sample();
        reset_n = 1'b0;
        chk(K_RDY, 16'd1, "mid_rst_rdy");
        chk(K_CTRL, 16'h0000, "mid_rst_ctrl");
        chk(K_IRQ, 16'd0, "mid_rst_irq");
        chk(K_SRC, 16'h0000, "mid_rst_src");
        chk(K_DST, 16'h0000, "mid_rst_dst");
        chk(K_LEN, 16'h0000, "mid_rst_len");
        for (int i = 0; i < 6; i++) begin
            rd(BASE + 16'(i), 8'h00, "rd_mid_rst");
        end
        reset_n = 1'b1;
        cycle();
        // New start while the engine is still busy stays stalled until busy falls
        wr(3'd4, 8'h01);
        wr(3'd5, 8'h80);
        for (int i = 0; i < 8; i++) begin
            chk(K_RDY, 16'd0, "busy_start_rdy");
            chk(K_CTRL, 16'h0080, "busy_start_ctrl");
            sample();
            cycle();
        end
        dma_busy = 1'b0;
        wait_idle(10, "busy_start_idle");
        chk(K_RDY, 16'd1, "busy_start_rdy_back");
        chk(K_CTRL, {8'h00, DONE_RD}, "busy_start_done_ctrl");
        sample();

        cycle();
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
